// File: rtl/text_display_pkg.sv
// Shared definitions for the text display path: scanner state encoding,
// default font cell geometry and a constant-function clog2.
package text_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } scan_state_e;

  localparam int DEFAULT_GLYPH_W = 8;
  localparam int DEFAULT_GLYPH_H = 16;

  // Ceiling log2 for elaboration-time widths; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/text_wrap_counter.sv
// Modulo-(MAX+1) up-counter. wrap flags an increment taken at MAX, which
// lets counters be chained by feeding one stage's wrap into the next inc.
module text_wrap_counter #(
  parameter int WIDTH = 4,
  parameter int MAX   = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  assign wrap = inc && (count == MAX_V);

  // Count register: reset and clear win over increment; wrap returns to 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/text_glyph_scan_counter.sv
// Glyph cell scanner: on start, walks every (optionally magnified) pixel of
// one character cell, presenting font and screen coordinates under a
// valid/ready handshake, then pulses done for one cycle.
//
// state   | meaning
// --------+------------------------------------------------------
// IDLE    | waiting for start; all outputs 0
// SCAN    | presenting pixels; counters advance per accepted pixel
// DONE    | one-cycle completion pulse, start ignored
module text_glyph_scan_counter
  import text_display_pkg::*;
#(
  parameter int GLYPH_W = DEFAULT_GLYPH_W,
  parameter int GLYPH_H = DEFAULT_GLYPH_H,
  parameter int SCALE   = 1,
  parameter int XW      = $clog2(GLYPH_W),
  parameter int YW      = $clog2(GLYPH_H),
  parameter int OXW     = $clog2(GLYPH_W * SCALE),
  parameter int OYW     = $clog2(GLYPH_H * SCALE)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           pix_ready,
  output logic           busy,
  output logic           pix_valid,
  output logic [XW-1:0]  c_x,
  output logic [YW-1:0]  c_y,
  output logic [OXW-1:0] o_x,
  output logic [OYW-1:0] o_y,
  output logic           last,
  output logic           done
);

  // Sub-pixel counters need at least one bit even when replication is off.
  localparam int SW = (SCALE > 1) ? clog2(SCALE) : 1;

  localparam logic [SW-1:0] SX_MAX = SW'(SCALE - 1);
  localparam logic [XW-1:0] CX_MAX = XW'(GLYPH_W - 1);
  localparam logic [YW-1:0] CY_MAX = YW'(GLYPH_H - 1);

  scan_state_e state;
  scan_state_e state_next;

  logic          xfer;
  logic          cnt_clear;
  logic [SW-1:0] sx_q;
  logic [SW-1:0] sy_q;
  logic [XW-1:0] cx_q;
  logic [YW-1:0] cy_q;
  logic          sx_wrap;
  logic          cx_wrap;
  logic          sy_wrap;
  logic          cy_wrap;

  assign pix_valid = (state == ST_SCAN);
  assign done      = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);

  assign xfer      = pix_valid && pix_ready;
  // Counters already wrap to 0 on the final transfer; clearing outside SCAN
  // additionally guarantees a clean origin for every new scan.
  assign cnt_clear = !pix_valid;

  // Replication counters exist only when the cell is magnified.
  generate
    if (SCALE > 1) begin : g_scale
      text_wrap_counter #(.WIDTH(SW), .MAX(SCALE - 1)) u_sx (
        .clk   (clk),
        .rst   (rst),
        .inc   (xfer),
        .clear (cnt_clear),
        .count (sx_q),
        .wrap  (sx_wrap)
      );

      text_wrap_counter #(.WIDTH(SW), .MAX(SCALE - 1)) u_sy (
        .clk   (clk),
        .rst   (rst),
        .inc   (cx_wrap),
        .clear (cnt_clear),
        .count (sy_q),
        .wrap  (sy_wrap)
      );
    end else begin : g_noscale
      assign sx_q    = '0;
      assign sy_q    = '0;
      assign sx_wrap = xfer;
      assign sy_wrap = cx_wrap;
    end
  endgenerate

  text_wrap_counter #(.WIDTH(XW), .MAX(GLYPH_W - 1)) u_cx (
    .clk   (clk),
    .rst   (rst),
    .inc   (sx_wrap),
    .clear (cnt_clear),
    .count (cx_q),
    .wrap  (cx_wrap)
  );

  text_wrap_counter #(.WIDTH(YW), .MAX(GLYPH_H - 1)) u_cy (
    .clk   (clk),
    .rst   (rst),
    .inc   (sy_wrap),
    .clear (cnt_clear),
    .count (cy_q),
    .wrap  (cy_wrap)
  );

  assign last = pix_valid && (sx_q == SX_MAX) && (cx_q == CX_MAX)
                && (sy_q == SX_MAX) && (cy_q == CY_MAX);

  assign c_x = pix_valid ? cx_q : '0;
  assign c_y = pix_valid ? cy_q : '0;
  assign o_x = pix_valid ? (OXW'(cx_q) * OXW'(SCALE) + OXW'(sx_q)) : '0;
  assign o_y = pix_valid ? (OYW'(cy_q) * OYW'(SCALE) + OYW'(sy_q)) : '0;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state; the outermost counter wrapping marks the final accepted pixel.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_SCAN;
      ST_SCAN: if (cy_wrap) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_text_glyph_scan_counter.sv
// Directed bench for the glyph scanner: default 8x16 cell and a SCALE=2 cell.
module tb_text_glyph_scan_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       pix_ready;
  logic       busy;
  logic       pix_valid;
  logic [2:0] c_x;
  logic [3:0] c_y;
  logic [2:0] o_x;
  logic [3:0] o_y;
  logic       last;
  logic       done;

  logic       s2_start;
  logic       s2_ready;
  logic       s2_busy;
  logic       s2_valid;
  logic [2:0] s2_cx;
  logic [3:0] s2_cy;
  logic [3:0] s2_ox;
  logic [4:0] s2_oy;
  logic       s2_last;
  logic       s2_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  text_glyph_scan_counter u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pix_ready (pix_ready),
    .busy      (busy),
    .pix_valid (pix_valid),
    .c_x       (c_x),
    .c_y       (c_y),
    .o_x       (o_x),
    .o_y       (o_y),
    .last      (last),
    .done      (done)
  );

  text_glyph_scan_counter #(.SCALE(2)) u_dut_s2 (
    .clk       (clk),
    .rst       (rst),
    .start     (s2_start),
    .pix_ready (s2_ready),
    .busy      (s2_busy),
    .pix_valid (s2_valid),
    .c_x       (s2_cx),
    .c_y       (s2_cy),
    .o_x       (s2_ox),
    .o_y       (s2_oy),
    .last      (s2_last),
    .done      (s2_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full default scan with pix_ready held high, checked pixel by pixel.
  task automatic run_full_scan(input string tag);
    start     = 1'b1;
    pix_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 128; n++) begin
      check({tag, " valid"}, pix_valid, 1);
      check({tag, " c_x"}, c_x, n % 8);
      check({tag, " c_y"}, c_y, n / 8);
      check({tag, " o_x"}, o_x, n % 8);
      check({tag, " o_y"}, o_y, n / 8);
      check({tag, " last"}, last, (n == 127) ? 1 : 0);
      check({tag, " done_in_scan"}, done, 0);
      tick();
    end
    check({tag, " done"}, done, 1);
    check({tag, " busy_done"}, busy, 1);
    check({tag, " valid_done"}, pix_valid, 0);
    check({tag, " c_x_done"}, c_x, 0);
    tick();
    check({tag, " done_clear"}, done, 0);
    check({tag, " busy_idle"}, busy, 0);
  endtask

  initial begin
    int n;
    int cyc;
    int sx, cx, sy, cy;

    rst       = 1'b0;
    start     = 1'b1;
    pix_ready = 1'b1;
    s2_start  = 1'b1;
    s2_ready  = 1'b1;

    // Reset held with start asserted.
    repeat (3) tick();
    check("rst busy", busy, 0);
    check("rst valid", pix_valid, 0);
    check("rst done", done, 0);
    check("rst last", last, 0);
    check("rst c_x", c_x, 0);
    check("rst c_y", c_y, 0);
    check("rst o_x", o_x, 0);
    check("rst o_y", o_y, 0);
    check("rst s2 busy", s2_busy, 0);
    start    = 1'b0;
    s2_start = 1'b0;
    rst      = 1'b1;
    tick();
    check("idle after rst", busy, 0);

    // Default scan, no backpressure.
    run_full_scan("plain");

    // Backpressure: pix_ready alternates 1,0.
    n   = 0;
    cyc = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (n < 128 && cyc < 1000) begin
      pix_ready = (cyc % 2 == 0);
      check("bp valid", pix_valid, 1);
      check("bp c_x", c_x, n % 8);
      check("bp c_y", c_y, n / 8);
      check("bp last", last, (n == 127) ? 1 : 0);
      tick();
      if (pix_ready) n++;
      cyc++;
    end
    check("bp transfers", n, 128);
    check("bp cycles", cyc, 255);
    check("bp done", done, 1);
    pix_ready = 1'b1;
    tick();
    check("bp done clear", done, 0);
    check("bp idle", busy, 0);

    // start held high: second scan only after DONE->IDLE.
    start = 1'b1;
    tick();
    for (int i = 1; i <= 128; i++) begin
      check("hold valid", pix_valid, 1);
      tick();
    end
    check("hold done", done, 1);
    tick();
    check("hold idle busy", busy, 0);
    check("hold idle valid", pix_valid, 0);
    tick();
    check("hold rescan valid", pix_valid, 1);
    check("hold rescan c_x", c_x, 0);
    check("hold rescan c_y", c_y, 0);
    start = 1'b0;
    rst   = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    // Abort by reset at transfer 40.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    check("abort pre c_x", c_x, 0);
    check("abort pre c_y", c_y, 5);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("abort valid", pix_valid, 0);
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort c_y", c_y, 0);
    check("abort o_y", o_y, 0);
    tick();
    check("abort no done", done, 0);
    run_full_scan("after_abort");

    // SCALE=2 cell.
    s2_start = 1'b1;
    s2_ready = 1'b1;
    tick();
    s2_start = 1'b0;
    for (int k = 0; k < 512; k++) begin
      sx = k % 2;
      cx = (k / 2) % 8;
      sy = (k / 16) % 2;
      cy = k / 32;
      check("s2 valid", s2_valid, 1);
      check("s2 c_x", s2_cx, cx);
      check("s2 c_y", s2_cy, cy);
      check("s2 o_x", s2_ox, cx * 2 + sx);
      check("s2 o_y", s2_oy, cy * 2 + sy);
      check("s2 last", s2_last, (k == 511) ? 1 : 0);
      if (k == 3) begin
        check("s2 t4 o_x", s2_ox, 3);
        check("s2 t4 c_x", s2_cx, 1);
      end
      if (k == 15) begin
        check("s2 t16 o_x", s2_ox, 15);
        check("s2 t16 c_x", s2_cx, 7);
        check("s2 t16 o_y", s2_oy, 0);
      end
      if (k == 16) begin
        check("s2 t17 o_x", s2_ox, 0);
        check("s2 t17 o_y", s2_oy, 1);
        check("s2 t17 c_y", s2_cy, 0);
      end
      if (k == 511) begin
        check("s2 final o_x", s2_ox, 15);
        check("s2 final o_y", s2_oy, 31);
      end
      tick();
    end
    check("s2 done", s2_done, 1);
    check("s2 valid_done", s2_valid, 0);
    tick();
    check("s2 idle", s2_busy, 0);
    check("s2 done clear", s2_done, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
